// File: rtl/soc_out_uart_tx.sv
// soc_out_uart_tx: turns every change on the SoC output port into a byte,
// buffers it in a small circular FIFO and sends it as an 8N1 UART frame.
module soc_out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       o_in,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int PTR_W  = CNT_W - 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            r_state;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_rd_ptr;
    logic [7:0]        r_last;
    logic [7:0]        r_shift;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic              r_tx;
    logic              r_busy;
    logic              r_overflow;

    logic              w_change;
    logic              w_empty;
    logic              w_full;
    logic              w_baud_end;
    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  w_count;
    logic [7:0]        w_head;

    // Pointers carry one extra wrap bit, so their difference is the occupancy
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_change   = (o_in != r_last);
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_head     = r_mem[r_rd_ptr[PTR_W-1:0]];
    // Pop when idle, or at the end of a stop bit so frames run back-to-back
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));
    // A simultaneous pop frees a slot, so a full FIFO can still accept
    assign w_push     = w_change && (!w_full || w_pop);

    // Change detection and FIFO write side; dropped bytes set the sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last     <= '0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (w_change) begin
            r_last <= o_in;
            if (w_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= o_in;
                r_wr_ptr                   <= r_wr_ptr + CNT_W'(1);
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transmit FSM: FIFO read side, baud/bit counters and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_shift  <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift  <= w_head;
                            r_rd_ptr <= r_rd_ptr + CNT_W'(1);
                            r_state  <= START;
                            r_tx     <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = w_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_soc_out_uart_tx.sv
// Bench for soc_out_uart_tx: a queue-based reference model predicts which bytes
// are accepted and when each frame starts; a UART monitor decodes tx and checks
// frames against the scoreboard, while a per-cycle checker tracks the status outputs.
module tb_soc_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int FRAME = 10 * CPB;

    logic          clk;
    logic          reset;
    logic [7:0]    o_in;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    soc_out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .o_in      (o_in),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    int         vectors    = 0;
    int         miscompares = 0;
    int         t          = 0;
    bit         started    = 0;
    logic [7:0] mq[$];
    exp_t       sb[$];
    logic [7:0] m_last     = 8'h00;
    logic       m_ovf      = 1'b0;
    int         frame_end  = 0;
    int         cur_start  = 0;
    logic [7:0] cur_byte   = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    // Reference model: byte queue plus frame timing arithmetic, advanced once per edge
    always @(posedge clk) begin
        t++;
        started = 1;
        if (reset) begin
            mq.delete();
            sb.delete();
            m_last    = 8'h00;
            m_ovf     = 1'b0;
            frame_end = t;
        end else begin
            if (mq.size() > 0 && t >= frame_end) begin
                cur_byte  = mq.pop_front();
                cur_start = t;
                frame_end = t + FRAME;
                sb.push_back('{b: cur_byte, start: t});
            end
            if (o_in != m_last) begin
                m_last = o_in;
                if (mq.size() < DEPTH) mq.push_back(o_in);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle status checks against the model
    always @(negedge clk) begin
        if (started) begin
            int   k;
            int   i;
            logic m_tx;
            m_tx = 1'b1;
            if (t < frame_end) begin
                k = t - cur_start;
                i = k / CPB;
                if (i == 0) m_tx = 1'b0;
                else if (i <= 8) m_tx = cur_byte[i-1];
                else m_tx = 1'b1;
            end
            chk("tx", 32'(tx), 32'(m_tx));
            chk("busy", 32'(busy), 32'(t < frame_end));
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // UART monitor: decode frames mid-bit and pop the scoreboard
    initial begin
        logic [9:0] bits;
        int         st;
        bit         aborted;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (started && !reset && tx === 1'b0) begin
                st      = t;
                aborted = 0;
                bits    = '0;
                for (int off = 1; off <= 9 * CPB + CPB / 2; off++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1;
                        break;
                    end
                    if (off % CPB == CPB / 2) bits[off / CPB] = tx;
                end
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        chk("frame_unexpected", 32'(bits[8:1]), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("frame_byte", 32'(bits[8:1]), 32'(e.b));
                        chk("frame_start", 32'(st), 32'(e.start));
                        chk("start_bit", 32'(bits[0]), 32'd0);
                        chk("stop_bit", 32'(bits[9]), 32'd1);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        bit drained;
        reset = 1'b1;
        o_in  = 8'h00;
        step(3);
        reset = 1'b0;
        step(20);

        // single byte
        o_in = 8'hA5;
        step(60);

        // back-to-back
        o_in = 8'h41; step(1);
        o_in = 8'h42; step(1);
        o_in = 8'h43; step(130);

        // held value: one frame only
        o_in = 8'h7E;
        step(100);

        // overflow: 0x06 is dropped
        for (int v = 1; v <= 6; v++) begin
            o_in = 8'(v);
            step(1);
        end
        step(5 * FRAME + 20);

        // reset during DATA bit 3 of 0xC3 with two bytes queued
        o_in = 8'hC3; step(1);
        o_in = 8'h11; step(1);
        o_in = 8'h22; step(16);
        reset = 1'b1;
        o_in  = 8'h00;
        step(2);
        reset = 1'b0;
        step(60);

        // random changes, including bursts that exceed the FIFO
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 99);
            if (r < 10) o_in = 8'($urandom_range(0, 255));
            step(1);
        end

        drained = 0;
        for (int c = 0; c < 2000; c++) begin
            if (sb.size() == 0 && mq.size() == 0 && t >= frame_end) begin
                drained = 1;
                break;
            end
            step(1);
        end
        chk("drain", 32'(drained), 32'd1);
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
